// File: rtl/bank_access_arbiter_pkg.sv
// Shared types and helpers for the bank access arbiter.
//   accessClass_t : which class (write or read) owns the bank in a cycle
//   addr_width()  : bank address width for a given bank depth
package bank_access_arbiter_pkg;

    typedef enum logic {
        CLS_WRITE = 1'b0,
        CLS_READ  = 1'b1
    } accessClass_t;

    // A depth of 1 still needs a one-bit address bus.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bank_access_arbiter_if.sv
// Requester and bank-side signals of the bank access arbiter.
//   slave  : the arbiter (takes requests and bank status, drives grants and bank strobes)
//   master : the environment (writers, readers and the bank itself)
// Handshake: a requester raises its wrReq/rdReq bit and holds it until the
// matching wrGnt/rdGnt bit is high in the same cycle; the access takes place
// in that cycle. Grants are combinational from the requests. Read data comes
// back one cycle after the read grant, marked by rdValid.
interface bank_access_arbiter_if
    import bank_access_arbiter_pkg::*;
#(
    parameter int NBR_WR_PORTS   = 4,
    parameter int NBR_RD_PORTS   = 4,
    parameter int PARALLEL_WIDTH = 512,
    parameter int BANK_ADDRESSES = 8
);
    localparam int AW = addr_width(BANK_ADDRESSES);

    logic [NBR_WR_PORTS-1:0]                wrReq;
    logic [NBR_WR_PORTS*PARALLEL_WIDTH-1:0] wrData;
    logic [NBR_WR_PORTS-1:0]                wrGnt;
    logic [AW-1:0]                          wrAddr;
    logic [NBR_RD_PORTS-1:0]                rdReq;
    logic [NBR_RD_PORTS*AW-1:0]             rdAddr;
    logic [NBR_RD_PORTS-1:0]                rdGnt;
    logic [NBR_RD_PORTS-1:0]                rdValid;
    logic [PARALLEL_WIDTH-1:0]              rdData;
    logic                                   bankWriteEnable;
    logic [PARALLEL_WIDTH-1:0]              bankWriteData;
    logic [AW-1:0]                          bankWriteAddress;
    logic                                   bankReadEnable;
    logic [AW-1:0]                          bankReadAddress;
    logic [PARALLEL_WIDTH-1:0]              bankReadData;
    logic [AW-1:0]                          bankFree;
    logic                                   bankInitDone;

    modport slave (
        input  wrReq, wrData, rdReq, rdAddr,
        input  bankWriteAddress, bankReadData, bankFree, bankInitDone,
        output wrGnt, wrAddr, rdGnt, rdValid, rdData,
        output bankWriteEnable, bankWriteData, bankReadEnable, bankReadAddress
    );

    modport master (
        output wrReq, wrData, rdReq, rdAddr,
        output bankWriteAddress, bankReadData, bankFree, bankInitDone,
        input  wrGnt, wrAddr, rdGnt, rdValid, rdData,
        input  bankWriteEnable, bankWriteData, bankReadEnable, bankReadAddress
    );

endinterface

// File: rtl/bank_access_arbiter_rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//   clk, rstn   : clock, asynchronous active-low reset
//   req[N]      : request vector
//   grantEnable : this arbiter's class owns the bank this cycle
//   gnt[N]      : one-hot grant, all zero unless grantEnable
// The first requester at or after the pointer wins; after a grant of index k
// the pointer moves to k+1 (wrapping) so k has lowest priority next time.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] req,
    input  logic         grantEnable,
    output logic [N-1:0] gnt
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] ptr_next;
    logic [N-1:0]     pick;

    always_comb begin : pick_proc
        int          idx;
        logic        found;
        logic [PTR_W-1:0] idx_v;
        pick  = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        idx_v = '0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_v = PTR_W'(idx);
            if (!found && req[idx_v]) begin
                found       = 1'b1;
                win         = idx_v;
                pick[idx_v] = 1'b1;
            end
        end
    end

    always_comb begin
        if (int'(win) == N - 1) begin
            ptr_next = '0;
        end else begin
            ptr_next = win + 1'b1;
        end
    end

    assign gnt = grantEnable ? pick : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (grantEnable && (|req)) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/bank_access_arbiter.sv
// Shares one single-port buffer bank between write and read requesters.
//   clk, rstn  : clock, asynchronous active-low reset
//   bus        : requester and bank signals (slave modport)
//   last_class : class that won the most recent grant (observable state)
// At most one bank access per cycle. Writes need free space and an
// initialised free list; when both classes are eligible the class that did
// not win last time goes next. Read data returns one cycle after the grant.
module bank_access_arbiter
    import bank_access_arbiter_pkg::*;
#(
    parameter int NBR_WR_PORTS   = 4,
    parameter int NBR_RD_PORTS   = 4,
    parameter int PARALLEL_WIDTH = 512,
    parameter int BANK_ADDRESSES = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    bank_access_arbiter_if.slave bus,
    output accessClass_t         last_class
);
    localparam int AW = addr_width(BANK_ADDRESSES);
    localparam int PW = PARALLEL_WIDTH;

    accessClass_t last_class_q;
    accessClass_t last_class_next;

    logic                    wr_elig;
    logic                    rd_elig;
    logic                    wr_en;
    logic                    rd_en;
    logic [NBR_WR_PORTS-1:0] wr_gnt;
    logic [NBR_RD_PORTS-1:0] rd_gnt;
    logic [NBR_RD_PORTS-1:0] rd_valid_q;
    logic [PW-1:0]           write_data;
    logic [AW-1:0]           read_addr;

    assign wr_elig = (|bus.wrReq) && (bus.bankFree != '0) && bus.bankInitDone;
    assign rd_elig = (|bus.rdReq) && bus.bankInitDone;

    // rstn gates the enables so grants drop the moment reset asserts,
    // not at the next clock edge.
    assign wr_en = rstn && wr_elig && (!rd_elig || (last_class_q == CLS_READ));
    assign rd_en = rstn && rd_elig && !wr_en;

    rr_arbiter #(.N(NBR_WR_PORTS)) u_wr_arb (
        .clk         (clk),
        .rstn        (rstn),
        .req         (bus.wrReq),
        .grantEnable (wr_en),
        .gnt         (wr_gnt)
    );

    rr_arbiter #(.N(NBR_RD_PORTS)) u_rd_arb (
        .clk         (clk),
        .rstn        (rstn),
        .req         (bus.rdReq),
        .grantEnable (rd_en),
        .gnt         (rd_gnt)
    );

    // One-hot AND-OR muxes; zero when no grant of that class.
    always_comb begin
        write_data = '0;
        for (int i = 0; i < NBR_WR_PORTS; i++) begin
            if (wr_gnt[i]) begin
                write_data = write_data | bus.wrData[i*PW +: PW];
            end
        end
    end

    always_comb begin
        read_addr = '0;
        for (int i = 0; i < NBR_RD_PORTS; i++) begin
            if (rd_gnt[i]) begin
                read_addr = read_addr | bus.rdAddr[i*AW +: AW];
            end
        end
    end

    // Class-alternation state: two-process form.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_class_q <= CLS_READ;
        end else begin
            last_class_q <= last_class_next;
        end
    end

    always_comb begin
        last_class_next = last_class_q;
        if (wr_en) begin
            last_class_next = CLS_WRITE;
        end else if (rd_en) begin
            last_class_next = CLS_READ;
        end
    end

    // Read response marker follows the bank's one-cycle latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_valid_q <= '0;
        end else begin
            rd_valid_q <= rd_gnt;
        end
    end

    assign last_class          = last_class_q;
    assign bus.wrGnt           = wr_gnt;
    assign bus.wrAddr          = bus.bankWriteAddress;
    assign bus.rdGnt           = rd_gnt;
    assign bus.rdValid         = rd_valid_q;
    assign bus.rdData          = bus.bankReadData;
    assign bus.bankWriteEnable = wr_en;
    assign bus.bankWriteData   = write_data;
    assign bus.bankReadEnable  = rd_en;
    assign bus.bankReadAddress = read_addr;

    // Requesters must hold a request until it is granted.
    for (genvar gi = 0; gi < NBR_WR_PORTS; gi++) begin : g_wr_hold
        a_wr_hold: assert property (@(posedge clk) disable iff (!rstn)
            (bus.wrReq[gi] && !bus.wrGnt[gi]) |=> bus.wrReq[gi]);
    end
    for (genvar gi = 0; gi < NBR_RD_PORTS; gi++) begin : g_rd_hold
        a_rd_hold: assert property (@(posedge clk) disable iff (!rstn)
            (bus.rdReq[gi] && !bus.rdGnt[gi]) |=> bus.rdReq[gi]);
    end

    a_enable_excl: assert property (@(posedge clk) disable iff (!rstn)
        !(bus.bankWriteEnable && bus.bankReadEnable));
    a_grant_excl: assert property (@(posedge clk) disable iff (!rstn)
        !((|bus.wrGnt) && (|bus.rdGnt)));

endmodule

// File: tb/tb_bank_access_arbiter.sv
// Bench for bank_access_arbiter: directed steps followed by a random phase,
// all checked against a reference model of the arbitration rules.
module tb_bank_access_arbiter;
    import bank_access_arbiter_pkg::*;

    localparam int NW = 4;
    localparam int NR = 4;
    localparam int PW = 512;
    localparam int BA = 8;
    localparam int AW = 3;

    logic         clk;
    logic         rstn;
    accessClass_t dbg_class;

    bank_access_arbiter_if #(
        .NBR_WR_PORTS(NW), .NBR_RD_PORTS(NR),
        .PARALLEL_WIDTH(PW), .BANK_ADDRESSES(BA)
    ) bus ();

    bank_access_arbiter #(
        .NBR_WR_PORTS(NW), .NBR_RD_PORTS(NR),
        .PARALLEL_WIDTH(PW), .BANK_ADDRESSES(BA)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .last_class (dbg_class)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bank storage model: one-cycle read latency
    logic [PW-1:0] mem [BA];
    always @(posedge clk) begin
        if (bus.bankReadEnable) begin
            bus.bankReadData <= mem[bus.bankReadAddress];
        end
    end

    // stimulus state
    logic [NW-1:0] wr_req;
    logic [PW-1:0] wr_data [NW];
    logic [NR-1:0] rd_req;
    logic [AW-1:0] rd_addr [NR];
    logic [AW-1:0] bank_free;
    logic [AW-1:0] bank_write_address;
    logic          init_done;

    // reference model state
    int            wr_ptr;
    int            rd_ptr;
    bit            last_write;
    logic [NR-1:0] exp_rv;
    logic [PW-1:0] exp_q [$];
    logic [NW-1:0] last_wg;
    logic [NR-1:0] last_rg;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] rand_word();
        logic [PW-1:0] w;
        for (int j = 0; j < PW / 32; j++) w[j*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic int first_at(input logic [31:0] req, input int ptr, input int n);
        for (int i = 0; i < n; i++) begin
            int idx;
            idx = (ptr + i) % n;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic drive();
        bus.wrReq            = wr_req;
        bus.rdReq            = rd_req;
        bus.bankFree         = bank_free;
        bus.bankWriteAddress = bank_write_address;
        bus.bankInitDone     = init_done;
        for (int i = 0; i < NW; i++) bus.wrData[i*PW +: PW] = wr_data[i];
        for (int i = 0; i < NR; i++) bus.rdAddr[i*AW +: AW] = rd_addr[i];
    endtask

    task automatic model_reset();
        wr_ptr     = 0;
        rd_ptr     = 0;
        last_write = 1'b0;
        exp_rv     = '0;
        exp_q.delete();
        last_wg    = '0;
        last_rg    = '0;
    endtask

    // One clock cycle with rstn high: drive, check at negedge, advance model.
    task automatic cycle_check();
        logic [NW-1:0] ewg;
        logic [NR-1:0] erg;
        logic [PW-1:0] ewd;
        logic [AW-1:0] era;
        logic [PW-1:0] exp_d;
        bit            we, re, dw, dr;
        int            k;
        drive();
        @(negedge clk);
        we = (wr_req != 0) && (bank_free != 0) && init_done;
        re = (rd_req != 0) && init_done;
        dw = we && (!re || !last_write);
        dr = re && !dw;
        ewg = '0; erg = '0; ewd = '0; era = '0; k = 0;
        if (dw) begin
            k = first_at(32'(wr_req), wr_ptr, NW);
            ewg[k] = 1'b1;
            ewd = wr_data[k];
        end
        if (dr) begin
            k = first_at(32'(rd_req), rd_ptr, NR);
            erg[k] = 1'b1;
            era = rd_addr[k];
        end
        check("wrGnt", PW'(bus.wrGnt), PW'(ewg));
        check("rdGnt", PW'(bus.rdGnt), PW'(erg));
        check("bankWriteEnable", PW'(bus.bankWriteEnable), PW'(dw));
        check("bankReadEnable", PW'(bus.bankReadEnable), PW'(dr));
        check("bankWriteData", bus.bankWriteData, ewd);
        check("bankReadAddress", PW'(bus.bankReadAddress), PW'(era));
        if (dw) check("wrAddr", PW'(bus.wrAddr), PW'(bank_write_address));
        check("rdValid", PW'(bus.rdValid), PW'(exp_rv));
        if (exp_rv != 0) begin
            exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check("rdData", bus.rdData, exp_d);
        end
        check("lastClass", PW'(dbg_class), PW'(last_write ? CLS_WRITE : CLS_READ));
        if (dw) begin
            wr_ptr     = (k + 1) % NW;
            last_write = 1'b1;
        end
        if (dr) begin
            rd_ptr     = (k + 1) % NR;
            last_write = 1'b0;
            exp_q.push_back(mem[era]);
        end
        exp_rv  = erg;
        last_wg = ewg;
        last_rg = erg;
        @(posedge clk);
        #1;
    endtask

    // Serve all outstanding requests, dropping each only after its grant.
    task automatic drain();
        bank_free = 3'd7;
        init_done = 1'b1;
        for (int c = 0; c < 40 && (wr_req != 0 || rd_req != 0); c++) begin
            cycle_check();
            wr_req = wr_req & ~last_wg;
            rd_req = rd_req & ~last_rg;
        end
        total++;
        assert (wr_req == 0 && rd_req == 0) else begin
            bad++;
            $error("FAIL drain_timeout observed wr=%0h rd=%0h expected 0", wr_req, rd_req);
        end
    endtask

    task automatic apply_reset();
        rstn      = 1'b0;
        wr_req    = '1;
        rd_req    = '1;
        init_done = 1'b1;
        bank_free = 3'd7;
        drive();
        @(negedge clk);
        check("rst_wrGnt", PW'(bus.wrGnt), '0);
        check("rst_rdGnt", PW'(bus.rdGnt), '0);
        check("rst_bankWriteEnable", PW'(bus.bankWriteEnable), '0);
        check("rst_bankReadEnable", PW'(bus.bankReadEnable), '0);
        check("rst_rdValid", PW'(bus.rdValid), '0);
        check("rst_lastClass", PW'(dbg_class), PW'(CLS_READ));
        @(posedge clk);
        #1;
        wr_req = '0;
        rd_req = '0;
        drive();
        rstn = 1'b1;
        model_reset();
    endtask

    initial begin
        rstn = 1'b0;
        wr_req = '0; rd_req = '0; bank_free = '0; bank_write_address = '0; init_done = 1'b0;
        for (int i = 0; i < NW; i++) wr_data[i] = rand_word();
        for (int i = 0; i < NR; i++) rd_addr[i] = '0;
        for (int i = 0; i < BA; i++) mem[i] = rand_word();
        model_reset();
        drive();
        @(posedge clk);
        #1;

        // 1: writes held off until the free list is initialised
        apply_reset();
        init_done = 1'b0; bank_free = 3'd7; bank_write_address = 3'd3; wr_req = 4'b0001;
        for (int c = 0; c < 3; c++) cycle_check();
        init_done = 1'b1;
        cycle_check();
        wr_req = wr_req & ~last_wg;
        drain();

        // 2: round robin among four held writers
        apply_reset();
        wr_req = 4'b1111; bank_free = 3'd7;
        for (int c = 0; c < 5; c++) begin
            bank_write_address = AW'(c);
            cycle_check();
        end
        drain();

        // 3: class alternation, write first after reset
        apply_reset();
        wr_req = 4'b0001; rd_req = 4'b0100; rd_addr[2] = 3'd4; bank_free = 3'd5;
        for (int c = 0; c < 6; c++) cycle_check();
        drain();

        // 4: full bank blocks writes, reads still served; one free slot admits one write
        apply_reset();
        bank_free = 3'd0; wr_req = 4'b0010; rd_req = 4'b0001; rd_addr[0] = 3'd6;
        cycle_check();
        rd_req = rd_req & ~last_rg;
        cycle_check();
        bank_free = 3'd1; bank_write_address = 3'd2;
        cycle_check();
        wr_req = wr_req & ~last_wg;
        drain();

        // 5: read data path timing
        apply_reset();
        mem[5] = PW'('hA5);
        rd_req = 4'b0010; rd_addr[1] = 3'd5;
        cycle_check();
        rd_req = '0;
        cycle_check();
        cycle_check();

        // 6: asynchronous reset in the middle of service
        apply_reset();
        rd_req = 4'b0001; rd_addr[0] = 3'd1;
        cycle_check();
        rd_req = '0; wr_req = 4'b1111; bank_free = 3'd7;
        drive();
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_wrGnt", PW'(bus.wrGnt), '0);
        check("midrst_bankWriteEnable", PW'(bus.bankWriteEnable), '0);
        check("midrst_rdValid", PW'(bus.rdValid), '0);
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cycle_check();
        wr_req = wr_req & ~last_wg;
        drain();

        // random traffic
        apply_reset();
        for (int i = 0; i < BA; i++) mem[i] = rand_word();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) wr_req = wr_req | NW'($urandom);
            if ($urandom_range(0, 2) == 0) rd_req = rd_req | NR'($urandom);
            for (int i = 0; i < NW; i++) wr_data[i] = rand_word();
            for (int i = 0; i < NR; i++) rd_addr[i] = AW'($urandom_range(0, BA - 1));
            bank_free          = ($urandom_range(0, 3) == 0) ? 3'd0 : AW'($urandom_range(1, 7));
            bank_write_address = AW'($urandom_range(0, BA - 1));
            init_done          = ($urandom_range(0, 15) != 0);
            cycle_check();
            wr_req = wr_req & ~last_wg;
            rd_req = rd_req & ~last_rg;
        end
        drain();
        cycle_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
